// File: rtl/mult_hilo_sequencer.sv
// mult_hilo_sequencer: issue/retire stage around a sequential 32x32 shift-add multiplier.
//
// Accepts an operand pair over In_valid/In_ready, latches the operands, pulses Mult_Run,
// waits for Mult_Ready, loads the 64-bit product into HI/LO and offers it downstream over
// Out_valid/Out_ready. A watchdog bounds the wait; on expiry HI=LO=0 and Timeout_err is set
// (sticky until Reset).
//
// Optional build macro: SIGNED_MULT_EN
//   defined   : In_signed=1 selects signed MULT (magnitudes to the multiplier, sign fix-up
//               on capture).
//   undefined : every operation is unsigned and In_signed is ignored.
//
// Ports:
//   clk               rising-edge clock
//   Reset             synchronous active-high reset
//   In_valid/In_ready operand handshake; In_signed, In_a, In_b operands
//   Mult_Run          one-cycle start pulse to the multiplier
//   Mult_Multiplier   latched operand A (held ISSUE through CAPTURE)
//   Mult_Multiplicand latched operand B (held ISSUE through CAPTURE)
//   Mult_Ready        multiplier product valid (level)
//   Mult_Product      multiplier 64-bit product
//   Out_valid/Out_ready result handshake
//   Hi_out/Lo_out     HI/LO architectural registers
//   Timeout_err       sticky watchdog flag
module mult_hilo_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic        In_signed,
  input  logic [31:0] In_a,
  input  logic [31:0] In_b,
  output logic        Mult_Run,
  output logic [31:0] Mult_Multiplier,
  output logic [31:0] Mult_Multiplicand,
  input  logic        Mult_Ready,
  input  logic [63:0] Mult_Product,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic [31:0] Hi_out,
  output logic [31:0] Lo_out,
  output logic        Timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapture,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              err_q, err_d;

  logic [31:0]       a_mag, b_mag;
  logic              neg_in;
  logic [63:0]       product_fixed;

`ifdef SIGNED_MULT_EN
  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as unsigned.
  assign a_mag         = (In_signed && In_a[31]) ? (32'd0 - In_a) : In_a;
  assign b_mag         = (In_signed && In_b[31]) ? (32'd0 - In_b) : In_b;
  assign neg_in        = In_signed & (In_a[31] ^ In_b[31]);
  assign product_fixed = neg_q ? (64'd0 - Mult_Product) : Mult_Product;
`else
  logic unused_in_signed;
  logic unused_neg_q;
  assign unused_in_signed = In_signed;
  assign unused_neg_q     = neg_q;
  assign a_mag            = In_a;
  assign b_mag            = In_b;
  assign neg_in           = 1'b0;
  assign product_fixed    = Mult_Product;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (In_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = neg_in;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q == 0 marks the first WAIT cycle, where Mult_Ready may be stale.
        if (Mult_Ready && (cnt_q != '0)) begin
          state_d = StCapture;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          hi_d    = '0;
          lo_d    = '0;
          state_d = StDone;
        end
      end
      StCapture: begin
        hi_d    = product_fixed[63:32];
        lo_d    = product_fixed[31:0];
        state_d = StDone;
      end
      StDone: begin
        if (Out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  // In_ready is held low while Reset is asserted so every output reads 0 during reset.
  assign In_ready          = (state_q == StIdle) && !Reset;
  assign Mult_Run          = (state_q == StIssue);
  assign Mult_Multiplier   = a_q;
  assign Mult_Multiplicand = b_q;
  assign Out_valid         = (state_q == StDone);
  assign Hi_out            = hi_q;
  assign Lo_out            = lo_q;
  assign Timeout_err       = err_q;

endmodule

// File: doc/mult_hilo_sequencer.md
Name: mult_hilo_sequencer

Overview:
- Issue/retire stage wrapped around the sequential 32x32 shift-add multiplier.
- Accepts an operand pair over a valid/ready handshake, latches and holds the operands, and pulses the multiplier's Run.
- Waits for the multiplier's Ready, then captures the 64-bit product into the HI/LO architectural registers and presents it downstream over a valid/ready handshake.
- Includes a cycle watchdog so a hung multiplier cannot stall the datapath.

Parameters:
- TIMEOUT_CYCLES, 40, max cycles in WAIT before the error path is taken (must exceed 33).
- CNT_W, 6, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- In_valid  input  1  operand pair valid
- In_ready  output  1  sequencer can accept an operand pair
- In_signed  input  1  1 = MULT (signed), 0 = MULTU; honoured only with SIGNED_MULT_EN
- In_a  input  32  multiplier operand
- In_b  input  32  multiplicand operand
- Mult_Run  output  1  one-cycle start pulse to the multiplier
- Mult_Multiplier  output  32  operand to the multiplier, held stable from ISSUE through CAPTURE
- Mult_Multiplicand  output  32  operand to the multiplier, held stable from ISSUE through CAPTURE
- Mult_Ready  input  1  multiplier product valid (level)
- Mult_Product  input  64  multiplier product
- Out_valid  output  1  result valid
- Out_ready  input  1  downstream accepts the result
- Hi_out  output  32  HI register
- Lo_out  output  32  LO register
- Timeout_err  output  1  sticky watchdog flag

Behaviour:
Reset values:
- All outputs 0; state IDLE; HI, LO, operand latches, watchdog counter and Timeout_err all cleared.
- Reset asserted in any state aborts the operation in that same clock edge. No partial HI/LO update is made.

States:
- IDLE: In_ready=1. On In_valid&&In_ready:
  - Latch In_a and In_b (magnitudes if signed; see Optional Feature).
  - Record the sign flag.
  - Go to ISSUE.
- ISSUE: Mult_Run=1 for exactly this one cycle; clear the watchdog; go to WAIT.
- WAIT: Mult_Run=0; the watchdog increments every cycle.
  - Mult_Ready is ignored in the first WAIT cycle, because it may still be high from the previous operation.
  - From the second WAIT cycle onward, Mult_Ready=1 -> CAPTURE.
  - If the counter reaches TIMEOUT_CYCLES before that: set Timeout_err, load HI=LO=0, go to DONE.
- CAPTURE: {HI,LO} <= corrected Mult_Product; go to DONE.
- DONE: Out_valid=1; Hi_out/Lo_out are stable.
  - On Out_ready=1: drop Out_valid and return to IDLE.
  - In_ready stays 0 until the cycle after that return, so there is no same-cycle back-to-back issue.

Timing and data rules:
- Latency: In accept -> Out_valid is (multiplier latency + 3) cycles minimum.
- Hi_out/Lo_out always show the last captured values. They change only at CAPTURE, at timeout, or at reset.
- Timeout_err is cleared only by Reset.
- Out_valid is held regardless of Out_ready stalls of any length.
- The operand ports (In_a, In_b, In_signed) are ignored outside IDLE.

Optional Feature:
Macro: SIGNED_MULT_EN

When defined:
- When In_signed=1, IDLE latches |In_a| and |In_b| (two's-complement absolute value) and records neg = In_a[31]^In_b[31].
- CAPTURE writes the 64-bit two's-complement negation of Mult_Product when neg=1.
- Edge case: |0x80000000| = 0x80000000 when treated as unsigned 32-bit; the product is still correct.

When undefined:
- In_signed is ignored; all operations are unsigned.
- No negation logic is present.

Test Plan:
- Unsigned: In_a=0x00000003, In_b=0x00000005 -> exactly one Mult_Run pulse; after Mult_Ready, Hi_out=0x00000000, Lo_out=0x0000000F, Out_valid=1.
- Max: In_a=In_b=0xFFFFFFFF -> Hi_out=0xFFFFFFFE, Lo_out=0x00000001.
- Signed (SIGNED_MULT_EN): In_signed=1, In_a=0xFFFFFFFE (-2), In_b=0x00000003 -> Mult_Multiplier=0x00000002; Hi_out=0xFFFFFFFF, Lo_out=0xFFFFFFFA.
- Backpressure: hold Out_ready=0 for 10 cycles after Out_valid -> Out_valid and HI/LO stable, In_ready=0; Out_ready=1 -> IDLE, In_ready=1 on the next cycle.
- Stuck Mult_Ready: Mult_Ready held 1 from before the issue -> ignored in the first WAIT cycle; with Mult_Ready tied 0 -> after 40 WAIT cycles Timeout_err=1, Hi_out=Lo_out=0, Out_valid=1.
- Reset in WAIT: assert Reset mid-operation -> next cycle all outputs 0, state IDLE, In_ready=1 after release; a later multiply completes normally.
